// File: rtl/bram_param_clr.sv
// Simple-dual-port coefficient RAM with selectable read latency and a clear sequencer
// that fills every word with CLR_VAL after reset or on request.
module bram_param_clr #(
    parameter int              DW      = 18,
    parameter int              AW      = 10,
    parameter int              OUT_REG = 0,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    output logic [DW-1:0] wr_dout,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dout,
    output logic          rd_valid
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] LAST_ADR = {AW{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] wr_addr_q;
    logic          rd_vld1;
    logic          rd_accept;

    // ready is a registered copy of (state == READY), so it gates every user port.
    assign rd_accept = ready & rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADR) begin
                        state   <= READY;
                        ready   <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        ready   <= 1'b0;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready   <= 1'b0;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // The sweep owns the write port while clearing; user writes only land when ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= CLR_VAL;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld1   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            rd_vld1 <= rd_accept;
            if (rd_accept) begin
                rd_addr_q <= rd_addr;
            end
            if (ready) begin
                wr_addr_q <= wr_addr;
            end
        end
    end

    // Addresses are registered and the array is read combinationally, which gives
    // write-first behaviour on a same-edge collision.
    assign wr_dout = ready ? mem[wr_addr_q] : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] dout_q;
            logic          rd_vld2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    rd_vld2 <= 1'b0;
                end else begin
                    rd_vld2 <= rd_vld1;
                    if (rd_vld1) begin
                        dout_q <= mem[rd_addr_q];
                    end
                end
            end

            assign rd_valid = rd_vld2;
            assign rd_dout  = rd_vld2 ? dout_q : '0;
        end else begin : g_no_out_reg
            assign rd_valid = rd_vld1;
            assign rd_dout  = rd_vld1 ? mem[rd_addr_q] : '0;
        end
    endgenerate

endmodule
